// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: latches the write-back bundle, tracks one outstanding
// data-RAM load, aligns/extends the returned word and drives the GPR/HILO/CP0 write ports.
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CP0_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      mem_read_flag_in,
    input  logic                      mem_sign_ext_flag_in,
    input  logic [3:0]                mem_sel_in,
    input  logic [DATA_WIDTH-1:0]     result_in,
    input  logic                      write_reg_en_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
    input  logic                      hilo_write_en_in,
    input  logic [DATA_WIDTH-1:0]     hi_in,
    input  logic [DATA_WIDTH-1:0]     lo_in,
    input  logic                      cp0_write_en_in,
    input  logic [CP0_ADDR_WIDTH-1:0] cp0_addr_in,
    input  logic [DATA_WIDTH-1:0]     cp0_write_data_in,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    input  logic                      ram_rvalid,
    output logic                      stall_req,
    output logic                      reg_write_en,
    output logic [REG_ADDR_WIDTH-1:0] reg_write_addr,
    output logic [DATA_WIDTH-1:0]     reg_write_data,
    output logic                      hilo_write_en,
    output logic [DATA_WIDTH-1:0]     hi_out,
    output logic [DATA_WIDTH-1:0]     lo_out,
    output logic                      cp0_write_en,
    output logic [CP0_ADDR_WIDTH-1:0] cp0_addr,
    output logic [DATA_WIDTH-1:0]     cp0_write_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                      read_flag_q;
    logic                      sign_ext_q;
    logic [3:0]                sel_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic                      wr_en_q;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
    logic                      hilo_en_q;
    logic [DATA_WIDTH-1:0]     hi_q;
    logic [DATA_WIDTH-1:0]     lo_q;
    logic                      cp0_en_q;
    logic [CP0_ADDR_WIDTH-1:0] cp0_addr_q;
    logic [DATA_WIDTH-1:0]     cp0_data_q;

    logic                      load_capture;
    logic [7:0]                byte_v;
    logic [15:0]               half_v;
    logic [DATA_WIDTH-1:0]     load_data;

    assign load_capture = !flush && !stall && mem_read_flag_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            read_flag_q <= 1'b0;
            sign_ext_q  <= 1'b0;
            sel_q       <= '0;
            result_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            hilo_en_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            cp0_en_q    <= 1'b0;
            cp0_addr_q  <= '0;
            cp0_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                read_flag_q <= 1'b0;
                sign_ext_q  <= 1'b0;
                sel_q       <= '0;
                result_q    <= '0;
                wr_en_q     <= 1'b0;
                wr_addr_q   <= '0;
                hilo_en_q   <= 1'b0;
                hi_q        <= '0;
                lo_q        <= '0;
                cp0_en_q    <= 1'b0;
                cp0_addr_q  <= '0;
                cp0_data_q  <= '0;
            end else if (!stall) begin
                read_flag_q <= mem_read_flag_in;
                sign_ext_q  <= mem_sign_ext_flag_in;
                sel_q       <= mem_sel_in;
                result_q    <= result_in;
                wr_en_q     <= write_reg_en_in;
                wr_addr_q   <= write_reg_addr_in;
                hilo_en_q   <= hilo_write_en_in;
                hi_q        <= hi_in;
                lo_q        <= lo_in;
                cp0_en_q    <= cp0_write_en_in;
                cp0_addr_q  <= cp0_addr_in;
                cp0_data_q  <= cp0_write_data_in;
            end
        end
    end

    // Lane select uses the latched byte address; misaligned accesses never arrive here.
    always_comb begin
        byte_v    = ram_rdata[{result_q[1:0], 3'b000} +: 8];
        half_v    = result_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_data = '0;
        case (sel_q)
            4'b0001: load_data = {{24{sign_ext_q & byte_v[7]}}, byte_v};
            4'b0011: load_data = {{16{sign_ext_q & half_v[15]}}, half_v};
            4'b1111: load_data = ram_rdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        stall_req      = 1'b0;
        reg_write_en   = 1'b0;
        reg_write_addr = wr_addr_q;
        reg_write_data = result_q;
        case (state_q)
            S_IDLE: begin
                // A completed load whose fields were held by stall must not write twice.
                reg_write_en = wr_en_q && !read_flag_q;
                if (load_capture) state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_req      = !ram_rvalid;
                reg_write_data = load_data;
                if (flush) begin
                    state_d = ram_rvalid ? S_IDLE : S_DRAIN;
                end else if (ram_rvalid) begin
                    reg_write_en = wr_en_q;
                    state_d      = load_capture ? S_WAIT : S_IDLE;
                end
            end
            S_DRAIN: begin
                stall_req = !ram_rvalid;
                if (ram_rvalid) state_d = load_capture ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hilo_write_en  = hilo_en_q;
    assign hi_out         = hi_q;
    assign lo_out         = lo_q;
    assign cp0_write_en   = cp0_en_q;
    assign cp0_addr       = cp0_addr_q;
    assign cp0_write_data = cp0_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU write-back, load alignment, RAM wait stalls,
// flush/drain, back-to-back loads and reset while a load is outstanding.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_read_flag_in, mem_sign_ext_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] result_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic        hilo_write_en_in;
    logic [31:0] hi_in, lo_in;
    logic        cp0_write_en_in;
    logic [7:0]  cp0_addr_in;
    logic [31:0] cp0_write_data_in;
    logic [31:0] ram_rdata;
    logic        ram_rvalid;
    logic        stall_req, reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        hilo_write_en;
    logic [31:0] hi_out, lo_out;
    logic        cp0_write_en;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_write_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_wb_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .flush                (flush),
        .mem_read_flag_in     (mem_read_flag_in),
        .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
        .mem_sel_in           (mem_sel_in),
        .result_in            (result_in),
        .write_reg_en_in      (write_reg_en_in),
        .write_reg_addr_in    (write_reg_addr_in),
        .hilo_write_en_in     (hilo_write_en_in),
        .hi_in                (hi_in),
        .lo_in                (lo_in),
        .cp0_write_en_in      (cp0_write_en_in),
        .cp0_addr_in          (cp0_addr_in),
        .cp0_write_data_in    (cp0_write_data_in),
        .ram_rdata            (ram_rdata),
        .ram_rvalid           (ram_rvalid),
        .stall_req            (stall_req),
        .reg_write_en         (reg_write_en),
        .reg_write_addr       (reg_write_addr),
        .reg_write_data       (reg_write_data),
        .hilo_write_en        (hilo_write_en),
        .hi_out               (hi_out),
        .lo_out               (lo_out),
        .cp0_write_en         (cp0_write_en),
        .cp0_addr             (cp0_addr),
        .cp0_write_data       (cp0_write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bubble();
        mem_read_flag_in     = 1'b0;
        mem_sign_ext_flag_in = 1'b0;
        mem_sel_in           = 4'b0000;
        result_in            = 32'h0;
        write_reg_en_in      = 1'b0;
        write_reg_addr_in    = 5'd0;
        hilo_write_en_in     = 1'b0;
        hi_in                = 32'h0;
        lo_in                = 32'h0;
        cp0_write_en_in      = 1'b0;
        cp0_addr_in          = 8'h0;
        cp0_write_data_in    = 32'h0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [31:0] addr,
                        input logic [3:0] sel, input logic sext);
        bubble();
        mem_read_flag_in     = 1'b1;
        mem_sign_ext_flag_in = sext;
        mem_sel_in           = sel;
        result_in            = addr;
        write_reg_en_in      = 1'b1;
        write_reg_addr_in    = rd;
    endtask

    task automatic wb(input string tag, input logic en, input logic [4:0] addr,
                      input logic [31:0] data, input logic sreq);
        chk({tag, ".en"}, {31'd0, reg_write_en}, {31'd0, en});
        if (en) begin
            chk({tag, ".addr"}, {27'd0, reg_write_addr}, {27'd0, addr});
            chk({tag, ".data"}, reg_write_data, data);
        end
        chk({tag, ".stall_req"}, {31'd0, stall_req}, {31'd0, sreq});
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        ram_rdata = 32'h0; ram_rvalid = 1'b0;
        bubble();
        hilo_write_en_in = 1'b1; hi_in = 32'hFFFF_0000; cp0_write_en_in = 1'b1;

        // reset clears everything even with a live bundle on the inputs
        tick(); tick(); settle();
        chk("rst.reg_en",  {31'd0, reg_write_en}, 32'd0);
        chk("rst.stall",   {31'd0, stall_req}, 32'd0);
        chk("rst.hilo_en", {31'd0, hilo_write_en}, 32'd0);
        chk("rst.hi",      hi_out, 32'd0);
        chk("rst.cp0_en",  {31'd0, cp0_write_en}, 32'd0);

        // ALU op with HILO and CP0 bundles
        rst = 1'b1;
        bubble();
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd8; result_in = 32'h1234;
        hilo_write_en_in = 1'b1; hi_in = 32'hAAAA_0001; lo_in = 32'h5555_0002;
        cp0_write_en_in = 1'b1; cp0_addr_in = 8'h61; cp0_write_data_in = 32'hDEAD_BEEF;
        tick(); bubble(); settle();
        wb("alu", 1'b1, 5'd8, 32'h0000_1234, 1'b0);
        chk("alu.hilo_en", {31'd0, hilo_write_en}, 32'd1);
        chk("alu.hi",      hi_out, 32'hAAAA_0001);
        chk("alu.lo",      lo_out, 32'h5555_0002);
        chk("alu.cp0_en",  {31'd0, cp0_write_en}, 32'd1);
        chk("alu.cp0_addr", {24'd0, cp0_addr}, 32'h61);
        chk("alu.cp0_data", cp0_write_data, 32'hDEAD_BEEF);

        // LB sign-extended, lane 3, single-cycle RAM
        tick(); load(5'd9, 32'h1000_0003, 4'b0001, 1'b1);
        tick(); bubble(); ram_rdata = 32'h80FF_0000; ram_rvalid = 1'b1; settle();
        wb("lb", 1'b1, 5'd9, 32'hFFFF_FF80, 1'b0);
        chk("lb.hilo_en", {31'd0, hilo_write_en}, 32'd0);
        tick(); ram_rvalid = 1'b0; settle();
        wb("lb.after", 1'b0, 5'd0, 32'h0, 1'b0);

        // LHU lane 1 with three RAM wait cycles
        load(5'd10, 32'h2000_0002, 4'b0011, 1'b0);
        tick(); bubble(); stall = 1'b1; settle();
        wb("lhu.w1", 1'b0, 5'd0, 32'h0, 1'b1);
        tick(); settle();
        wb("lhu.w2", 1'b0, 5'd0, 32'h0, 1'b1);
        tick(); settle();
        wb("lhu.w3", 1'b0, 5'd0, 32'h0, 1'b1);
        tick(); stall = 1'b0; ram_rdata = 32'hABCD_1111; ram_rvalid = 1'b1; settle();
        wb("lhu.done", 1'b1, 5'd10, 32'h0000_ABCD, 1'b0);
        tick(); ram_rvalid = 1'b0;

        // LH sign-extended lane 0, then LBU lane 1
        load(5'd3, 32'h0000_0100, 4'b0011, 1'b1);
        tick(); load(5'd4, 32'h0000_0101, 4'b0001, 1'b0);
        ram_rdata = 32'h1234_8001; ram_rvalid = 1'b1; settle();
        wb("lh", 1'b1, 5'd3, 32'hFFFF_8001, 1'b0);
        tick(); bubble(); ram_rdata = 32'h0000_9A00; settle();
        wb("lbu", 1'b1, 5'd4, 32'h0000_009A, 1'b0);

        // undefined access size yields zero data
        tick(); load(5'd5, 32'h0000_0000, 4'b0101, 1'b1);
        ram_rvalid = 1'b0;
        tick(); bubble(); ram_rdata = 32'hFFFF_FFFF; ram_rvalid = 1'b1; settle();
        wb("badsel", 1'b1, 5'd5, 32'h0, 1'b0);
        tick(); ram_rvalid = 1'b0;

        // flush while waiting: drain the late response without writing
        load(5'd11, 32'h0000_0010, 4'b1111, 1'b0);
        tick(); bubble(); flush = 1'b1; settle();
        wb("flush.wait", 1'b0, 5'd0, 32'h0, 1'b1);
        tick(); flush = 1'b0; stall = 1'b1; settle();
        wb("drain.norv", 1'b0, 5'd0, 32'h0, 1'b1);
        tick(); stall = 1'b0; ram_rdata = 32'h0000_0055; ram_rvalid = 1'b1; settle();
        wb("drain.rv", 1'b0, 5'd0, 32'h0, 1'b0);
        tick(); ram_rvalid = 1'b0; settle();
        wb("drain.idle", 1'b0, 5'd0, 32'h0, 1'b0);

        // back-to-back LW/LW with single-cycle RAM
        load(5'd12, 32'h0000_0020, 4'b1111, 1'b0);
        tick(); load(5'd13, 32'h0000_0024, 4'b1111, 1'b0);
        ram_rdata = 32'h1111_1111; ram_rvalid = 1'b1; settle();
        wb("lw1", 1'b1, 5'd12, 32'h1111_1111, 1'b0);
        tick(); bubble(); ram_rdata = 32'h2222_2222; settle();
        wb("lw2", 1'b1, 5'd13, 32'h2222_2222, 1'b0);
        tick(); ram_rvalid = 1'b0; settle();
        wb("lw.idle", 1'b0, 5'd0, 32'h0, 1'b0);

        // reset while waiting; a stray response afterwards is ignored
        load(5'd14, 32'h0000_0030, 4'b1111, 1'b0);
        tick(); bubble(); settle();
        wb("rstwait.pre", 1'b0, 5'd0, 32'h0, 1'b1);
        rst = 1'b0;
        tick(); settle();
        wb("rstwait.post", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rstwait.addr", {27'd0, reg_write_addr}, 32'd0);
        chk("rstwait.data", reg_write_data, 32'd0);
        rst = 1'b1; ram_rdata = 32'hFFFF_FFFF; ram_rvalid = 1'b1; settle();
        wb("stray", 1'b0, 5'd0, 32'h0, 1'b0);
        tick(); ram_rvalid = 1'b0; settle();
        wb("stray.idle", 1'b0, 5'd0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
